// File: rtl/mem_stage_access.sv
// mem_stage_access: consumer end of the EX/MEM register. Performs data-memory
// loads/stores over a req/ack handshake, stalls upstream while an access is
// outstanding, and registers the selected result into the MEM/WB (W) stage.
// Optional build macro: MEM_TIMEOUT_EN enables a BUSY-cycle watchdog that
// aborts an unacknowledged access after TIMEOUT_CYCLES and pulses bus_err.
module mem_stage_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic        mem_write_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  write_reg_m,
  input  logic        upper_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        reg_write_w,
  output logic [4:0]  write_reg_w,
  output logic [31:0] result_w,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state;
  logic        r_rw_lat;
  logic [4:0]  r_wr_lat;
  logic        r_load_lat;
  logic        w_access;
  logic        w_timeout;
  logic        w_stall;
  logic [31:0] w_alu_sel;

  assign w_access  = mem_to_reg_m | mem_write_m;
  assign w_alu_sel = upper_m ? {alu_result_m[15:0], 16'h0000} : alu_result_m;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  // Abort fires only when no ack arrives in the limit cycle, so ack always wins.
  assign w_timeout = (r_state == BUSY) && !dmem_ack && (r_cnt == CW'(TIMEOUT_CYCLES));

  // BUSY-cycle counter and single-cycle abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= w_timeout;
      if (r_state == IDLE)
        r_cnt <= '0;
      else if (!dmem_ack && !w_timeout)
        r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // Upstream stall: request in IDLE, or waiting for ack in BUSY
  always_comb begin
    w_stall = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE:    w_stall = w_access;
        BUSY:    w_stall = !dmem_ack && !w_timeout;
        default: w_stall = 1'b0;
      endcase
    end
  end

  assign stall_m = w_stall;

  // Access FSM, memory request registers and W-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      r_rw_lat    <= 1'b0;
      r_wr_lat    <= '0;
      r_load_lat  <= 1'b0;
      reg_write_w <= 1'b0;
      write_reg_w <= '0;
      result_w    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_state     <= BUSY;
            dmem_req    <= 1'b1;
            dmem_we     <= mem_write_m;
            dmem_addr   <= {alu_result_m[31:2], 2'b00};
            dmem_wdata  <= write_data_m;
            r_rw_lat    <= reg_write_m;
            r_wr_lat    <= write_reg_m;
            // A simultaneous load+store request behaves as a store.
            r_load_lat  <= mem_to_reg_m & ~mem_write_m;
            reg_write_w <= 1'b0;
          end else begin
            reg_write_w <= reg_write_m;
            write_reg_w <= write_reg_m;
            result_w    <= w_alu_sel;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            r_state     <= IDLE;
            dmem_req    <= 1'b0;
            reg_write_w <= r_rw_lat;
            write_reg_w <= r_wr_lat;
            if (r_load_lat)
              result_w <= dmem_rdata;
          end else if (w_timeout) begin
            r_state     <= IDLE;
            dmem_req    <= 1'b0;
            reg_write_w <= 1'b0;
            result_w    <= '0;
          end else begin
            reg_write_w <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: randomized pass-through and memory
// transactions against a transaction-level model of the W-stage outputs.
module tb_mem_stage_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_m, mem_to_reg_m, mem_write_m, upper_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [4:0]  write_reg_m;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_m, reg_write_w, bus_err;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // model of the architecturally visible W-stage state
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  mem_stage_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .write_reg_m(write_reg_m),
    .upper_m(upper_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
    .result_w(result_w), .bus_err(bus_err)
  );

  task automatic set_nop();
    reg_write_m = 1'b0; mem_to_reg_m = 1'b0; mem_write_m = 1'b0; upper_m = 1'b0;
    alu_result_m = '0; write_data_m = '0; write_reg_m = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reg_write_m = 1'b1; mem_to_reg_m = 1'b1; mem_write_m = 1'b1; upper_m = 1'b0;
    alu_result_m = $urandom; write_data_m = $urandom; write_reg_m = 5'd7;
    dmem_ack = 1'b0; dmem_rdata = '0;
    @(negedge clk); @(negedge clk);
    #1;
    n_vec++; if (stall_m !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_m); end
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", dmem_req); end
    n_vec++; if (dmem_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", dmem_we); end
    n_vec++; if (dmem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", dmem_addr); end
    n_vec++; if (dmem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", dmem_wdata); end
    n_vec++; if (reg_write_w !== 1'b0) begin n_err++; $display("FAIL rst_rw: got %b want 0", reg_write_w); end
    n_vec++; if (write_reg_w !== 5'd0) begin n_err++; $display("FAIL rst_wr: got %0d want 0", write_reg_w); end
    n_vec++; if (result_w !== 32'h0) begin n_err++; $display("FAIL rst_res: got %h want 0", result_w); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_berr: got %b want 0", bus_err); end
    m_rw = 1'b0; m_wr = '0; m_res = '0;
    set_nop();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one non-memory instruction; an optional stray ack must be ignored
  task automatic do_pass(input logic rw, input logic [4:0] wr, input logic [31:0] alu,
                         input logic up, input logic ack);
    reg_write_m = rw; write_reg_m = wr; alu_result_m = alu; upper_m = up;
    mem_to_reg_m = 1'b0; mem_write_m = 1'b0; write_data_m = $urandom;
    dmem_ack = ack; dmem_rdata = $urandom;
    #1;
    n_vec++; if (stall_m !== 1'b0) begin n_err++; $display("FAIL pass_stall: got %b want 0", stall_m); end
    @(negedge clk);
    dmem_ack = 1'b0;
    m_rw = rw; m_wr = wr; m_res = up ? (alu << 16) : alu;
    n_vec++; if (reg_write_w !== m_rw) begin n_err++; $display("FAIL pass_rw: got %b want %b", reg_write_w, m_rw); end
    n_vec++; if (write_reg_w !== m_wr) begin n_err++; $display("FAIL pass_wr: got %0d want %0d", write_reg_w, m_wr); end
    n_vec++; if (result_w !== m_res) begin n_err++; $display("FAIL pass_res: got %h want %h", result_w, m_res); end
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL pass_req: got %b want 0", dmem_req); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL pass_berr: got %b want 0", bus_err); end
  endtask

  // one memory access acknowledged dly cycles after the request appears
  task automatic do_access(input logic rw, input logic mr, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                           input int unsigned dly, input logic use_fix, input logic [31:0] rd_fix);
    logic [31:0] rd;
    logic [31:0] exp_addr;
    exp_addr = alu & 32'hFFFF_FFFC;
    rd = '0;
    reg_write_m = rw; mem_to_reg_m = mr; mem_write_m = mw; alu_result_m = alu;
    write_data_m = wd; write_reg_m = wr; upper_m = $urandom; dmem_ack = 1'b0;
    #1;
    n_vec++; if (stall_m !== 1'b1) begin n_err++; $display("FAIL acc_stall_idle: got %b want 1", stall_m); end
    @(negedge clk);
    for (int unsigned k = 0; k <= dly; k++) begin
      n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL acc_req: got %b want 1", dmem_req); end
      n_vec++; if (dmem_we !== mw) begin n_err++; $display("FAIL acc_we: got %b want %b", dmem_we, mw); end
      n_vec++; if (dmem_addr !== exp_addr) begin n_err++; $display("FAIL acc_addr: got %h want %h", dmem_addr, exp_addr); end
      n_vec++; if (dmem_wdata !== wd) begin n_err++; $display("FAIL acc_wdata: got %h want %h", dmem_wdata, wd); end
      n_vec++; if (reg_write_w !== 1'b0) begin n_err++; $display("FAIL acc_bubble: got %b want 0", reg_write_w); end
      n_vec++; if (write_reg_w !== m_wr) begin n_err++; $display("FAIL acc_wr_hold: got %0d want %0d", write_reg_w, m_wr); end
      n_vec++; if (result_w !== m_res) begin n_err++; $display("FAIL acc_res_hold: got %h want %h", result_w, m_res); end
      // upstream keeps changing while BUSY; the latched copies must win
      reg_write_m = $urandom; mem_to_reg_m = $urandom; mem_write_m = $urandom;
      alu_result_m = $urandom; write_data_m = $urandom; write_reg_m = $urandom; upper_m = $urandom;
      rd = (use_fix && k == dly) ? rd_fix : $urandom;
      dmem_rdata = rd;
      dmem_ack = (k == dly);
      #1;
      n_vec++; if (stall_m !== (k != dly)) begin n_err++; $display("FAIL acc_stall_busy: got %b want %b", stall_m, (k != dly)); end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    m_rw = rw; m_wr = wr;
    if (mr && !mw) m_res = rd;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL acc_req_drop: got %b want 0", dmem_req); end
    n_vec++; if (reg_write_w !== m_rw) begin n_err++; $display("FAIL acc_rw: got %b want %b", reg_write_w, m_rw); end
    n_vec++; if (write_reg_w !== m_wr) begin n_err++; $display("FAIL acc_wr: got %0d want %0d", write_reg_w, m_wr); end
    n_vec++; if (result_w !== m_res) begin n_err++; $display("FAIL acc_res: got %h want %h", result_w, m_res); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL acc_berr: got %b want 0", bus_err); end
    set_nop();
  endtask

  task automatic test_passthrough();
    do_pass(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++)
      do_pass(1'($urandom), 5'($urandom), $urandom, 1'b0, 1'($urandom));
  endtask

  task automatic test_upper();
    do_pass(1'b1, 5'd9, 32'h0000_ABCD, 1'b1, 1'b0);
    n_vec++; if (result_w !== 32'hABCD_0000) begin n_err++; $display("FAIL upper_res: got %h want abcd0000", result_w); end
    for (int i = 0; i < 10; i++)
      do_pass(1'b1, 5'($urandom), $urandom, 1'b1, 1'b0);
  endtask

  task automatic test_load();
    do_access(1'b1, 1'b1, 1'b0, 32'h0000_0107, 32'h0, 5'd12, 3, 1'b1, 32'hCAFE_F00D);
    n_vec++; if (result_w !== 32'hCAFE_F00D) begin n_err++; $display("FAIL load_res: got %h want cafef00d", result_w); end
    n_vec++; if (reg_write_w !== 1'b1) begin n_err++; $display("FAIL load_rw: got %b want 1", reg_write_w); end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b0, 1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 5'd3, 0, 1'b0, '0);
    do_access(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 5'd4, 0, 1'b0, '0);
    // load and store together behave as a store
    do_access(1'b0, 1'b1, 1'b1, $urandom, $urandom, 5'($urandom), 1, 1'b0, '0);
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_pass(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom));
      else begin
        logic mw;
        mw = 1'($urandom);
        do_access(!mw, !mw || 1'($urandom), mw, $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 5), 1'b0, '0);
      end
    end
  endtask

  task automatic test_reset_busy();
    reg_write_m = 1'b1; mem_to_reg_m = 1'b1; mem_write_m = 1'b0;
    alu_result_m = 32'h0000_4444; write_reg_m = 5'd20; dmem_ack = 1'b0;
    @(negedge clk);
    n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rb_req_busy: got %b want 1", dmem_req); end
    rst = 1'b1;
    #1;
    n_vec++; if (stall_m !== 1'b0) begin n_err++; $display("FAIL rb_stall: got %b want 0", stall_m); end
    @(negedge clk);
    rst = 1'b0;
    set_nop();
    m_rw = 1'b0; m_wr = '0; m_res = '0;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rb_req: got %b want 0", dmem_req); end
    n_vec++; if (reg_write_w !== 1'b0) begin n_err++; $display("FAIL rb_rw: got %b want 0", reg_write_w); end
    n_vec++; if (write_reg_w !== 5'd0) begin n_err++; $display("FAIL rb_wr: got %0d want 0", write_reg_w); end
    n_vec++; if (result_w !== 32'h0) begin n_err++; $display("FAIL rb_res: got %h want 0", result_w); end
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    n_vec++; if (stall_m !== 1'b0) begin n_err++; $display("FAIL rb_late_stall: got %b want 0", stall_m); end
    @(negedge clk);
    dmem_ack = 1'b0;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rb_late_req: got %b want 0", dmem_req); end
    n_vec++; if (result_w !== 32'h0) begin n_err++; $display("FAIL rb_late_res: got %h want 0", result_w); end
    n_vec++; if (reg_write_w !== 1'b0) begin n_err++; $display("FAIL rb_late_rw: got %b want 0", reg_write_w); end
    do_access(1'b1, 1'b1, 1'b0, $urandom, 32'h0, 5'd21, 1, 1'b0, '0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    reg_write_m = 1'b1; mem_to_reg_m = 1'b1; mem_write_m = 1'b0;
    alu_result_m = 32'h0000_0800; write_reg_m = 5'd6; dmem_ack = 1'b0;
    @(negedge clk);
    for (int unsigned k = 0; k <= TO; k++) begin
      n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_berr_early: got %b want 0", bus_err); end
      #1;
      n_vec++; if (stall_m !== (k != TO)) begin n_err++; $display("FAIL to_stall: got %b want %b", stall_m, (k != TO)); end
      @(negedge clk);
    end
    set_nop();
    m_rw = 1'b0; m_res = '0;
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_berr: got %b want 1", bus_err); end
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL to_req: got %b want 0", dmem_req); end
    n_vec++; if (reg_write_w !== 1'b0) begin n_err++; $display("FAIL to_rw: got %b want 0", reg_write_w); end
    n_vec++; if (result_w !== 32'h0) begin n_err++; $display("FAIL to_res: got %h want 0", result_w); end
    do_pass(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    do_access(1'b1, 1'b1, 1'b0, $urandom, 32'h0, 5'd8, 2, 1'b0, '0);
    // ack in the limit cycle completes normally
    do_access(1'b1, 1'b1, 1'b0, $urandom, 32'h0, 5'd9, TO, 1'b0, '0);
  endtask
`endif

  initial begin
    set_nop();
    rst = 1'b1;
    m_rw = 1'b0; m_wr = '0; m_res = '0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_upper();
    test_load();
    test_back_to_back();
    test_random_mix();
    test_reset_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Consumer end of the EX/MEM pipeline register.
- Takes the M-stage control and data fields and performs data-memory loads and stores over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the selected result into the MEM/WB stage (W-stage outputs).

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles without dmem_ack before abort (only used with MEM_TIMEOUT_EN); counter width = clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
reg_write_m  input  1  M-stage register-write enable
mem_to_reg_m  input  1  M-stage load (result comes from memory)
mem_write_m  input  1  M-stage store
alu_result_m  input  32  M-stage ALU result / memory address
write_data_m  input  32  M-stage store data
write_reg_m  input  5  M-stage destination register
upper_m  input  1  M-stage LUI-style upper-immediate select
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1=store, 0=load; valid while dmem_req
dmem_addr  output  32  word address {alu_result_m[31:2],2'b00}, latched
dmem_wdata  output  32  store data, latched
dmem_ack  input  1  memory completion, one-cycle pulse
dmem_rdata  input  32  load data, valid when dmem_ack
stall_m  output  1  hold F/D/E stages and EX/MEM register
reg_write_w  output  1  W-stage register-write enable
write_reg_w  output  5  W-stage destination register
result_w  output  32  W-stage write-back value
bus_err  output  1  one-cycle pulse on access abort

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst.
- Reset values:
  - state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - reg_write_w=0, write_reg_w=0, result_w=0, bus_err=0.
  - stall_m forced 0 while rst=1.
- access = mem_to_reg_m | mem_write_m.
- FSM states: IDLE, BUSY.
- IDLE, access=0 (pass-through): stall_m=0. At the edge, W-regs capture reg_write_m and write_reg_m. result_w captures {alu_result_m[15:0],16'h0000} if upper_m, else alu_result_m. Latency 1 cycle.
- IDLE, access=1:
  - stall_m=1 combinationally.
  - At the edge: go to BUSY; latch dmem_addr, dmem_wdata, dmem_we=mem_write_m, plus reg_write_m and write_reg_m; set dmem_req=1.
  - W-stage gets a bubble: reg_write_w<=0; write_reg_w and result_w hold.
- BUSY, dmem_ack=0: stall_m=1, request fields held stable, bubble into W.
- BUSY, dmem_ack=1:
  - stall_m=0; at the edge dmem_req<=0 and state goes to IDLE.
  - W-regs capture the latched reg_write and write_reg.
  - result_w<=dmem_rdata for a load; for a store result_w holds and reg_write_w takes the latched value (0 for a well-formed store).
  - The EX/MEM register advances on the same edge.
- Minimum memory-op latency is 2 cycles (IDLE + BUSY-with-ack). Back-to-back accesses each pay the IDLE cycle; dmem_req drops for at least one cycle between requests.
- dmem_ack in IDLE is ignored, with no state change.
- Inputs are sampled only in IDLE; changes during BUSY are ignored because the latched copies drive the bus.
- rst in BUSY: dmem_req=0 on the next cycle and the access is abandoned; the memory must tolerate a dropped request. A late ack after reset is ignored.
- mem_to_reg_m and mem_write_m both high: treated as a store (dmem_we=1), result not loaded.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a BUSY-cycle counter clears on entry to BUSY. When it reaches TIMEOUT_CYCLES with no ack:
  - state goes to IDLE; dmem_req<=0.
  - stall_m=0 in that cycle.
  - reg_write_w<=0, result_w<=0.
  - bus_err pulses 1 for one cycle.
- Ack in the same cycle as timeout: ack wins, bus_err=0.
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Test Plan:
- Pass-through: reg_write_m=1, write_reg_m=5, alu_result_m=32'h1234_5678, no access -> next cycle reg_write_w=1, write_reg_w=5, result_w=32'h1234_5678, stall_m never 1.
- Upper: upper_m=1, alu_result_m=32'h0000_ABCD -> result_w=32'hABCD_0000.
- Load, ack 3 cycles after req: alu_result_m=32'h0000_0107, dmem_rdata=32'hCAFE_F00D -> dmem_addr=32'h0000_0104, dmem_we=0, stall_m high 4 cycles, then result_w=32'hCAFE_F00D with reg_write_w=1; bubbles before that.
- Store then load back-to-back, ack immediate: dmem_we=1 with dmem_wdata=write_data_m; dmem_req low one cycle between requests; reg_write_w=0 for the store.
- Reset in BUSY: dmem_req=0 the next cycle, all W outputs 0; ack one cycle later causes no change.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> bus_err single pulse, stall_m releases, reg_write_w=0; a second access then completes normally.
